// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDWAIT  = 2'd1,
        MEMWAIT = 2'd2
    } hz_state_t;

    // Register specifiers are zero-extended to this width before comparison.
    localparam int REG_W_MAX = 8;
    localparam logic [REG_W_MAX-1:0] REG_ZERO = '0;

    // Reading $zero never creates a true dependency.
    function automatic logic hit(
        input logic [REG_W_MAX-1:0] r,
        input logic [REG_W_MAX-1:0] rs,
        input logic [REG_W_MAX-1:0] rt,
        input logic                 uses_rt
    );
        return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// sat_counter: free-running event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects en one cycle later. Backpressure: none; en is sampled every cycle.
// clear has priority over en.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall, dmem-busy freeze and EX branch flush control for the ID stage.
// Latency: all pipeline controls are combinational from current state and inputs; stall_count lags by one cycle.
// Backpressure: dmem busy freezes the whole pipe, load-use holds PC and IF/ID, taken branch flushes IF/ID.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_count
);

    localparam int                REM_W      = $clog2(LOAD_LAT + 1);
    localparam logic [REM_W-1:0]  REM_RELOAD = REM_W'(LOAD_LAT - 1);

    hz_state_t        state_q, state_d;
    hz_state_t        ret_q, ret_d;
    hz_state_t        eff_state;
    logic [REG_W-1:0] pend_q, pend_d;
    logic [REM_W-1:0] rem_q, rem_d;

    logic mem_wait, lu_ex, lu_pend;
    logic stall, bubble, flush, freeze;

    always_comb begin
        // A freeze is transparent: decisions are made as if still in the state it interrupted.
        eff_state = (state_q == MEMWAIT) ? ret_q : state_q;
        mem_wait  = mem_access && !dmem_ready;
        lu_ex     = id_ex_mem_read &&
                    hit(REG_W_MAX'(id_ex_rt), REG_W_MAX'(if_id_rs), REG_W_MAX'(if_id_rt), if_id_uses_rt);
        lu_pend   = (eff_state == LDWAIT) && (rem_q != '0) &&
                    hit(REG_W_MAX'(pend_q), REG_W_MAX'(if_id_rs), REG_W_MAX'(if_id_rt), if_id_uses_rt);

        state_d = eff_state;
        ret_d   = ret_q;
        pend_d  = pend_q;
        rem_d   = rem_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        freeze  = 1'b0;

        if (mem_wait) begin
            freeze  = 1'b1;
            state_d = MEMWAIT;
            ret_d   = eff_state;
        end else if (ex_branch_taken) begin
            flush   = 1'b1;
            bubble  = 1'b1;
            state_d = RUN;
            rem_d   = '0;
        end else if (lu_ex) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d = LDWAIT;
                pend_d  = id_ex_rt;
                rem_d   = REM_RELOAD;
            end
        end else if (lu_pend) begin
            stall  = 1'b1;
            bubble = 1'b1;
            rem_d  = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) begin
                state_d = RUN;
            end
        end else begin
            state_d = RUN;
            rem_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ret_q   <= RUN;
            pend_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            pend_q  <= pend_d;
            rem_q   <= rem_d;
        end
    end

    // Outputs are forced to free-running values for as long as reset is held.
    assign pc_write     = !rst_n || !(freeze || stall);
    assign if_id_write  = pc_write;
    assign if_id_flush  = rst_n && flush;
    assign id_ex_bubble = rst_n && bubble;
    assign pipe_freeze  = rst_n && freeze;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!pc_write),
        .clear (1'b0),
        .count (stall_count)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Three DUT configurations share one stimulus stream; each is tracked by a bubble-budget model.
module tb_hazard_stall_ctrl;

    localparam int REG_W = 5;
    localparam int N     = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ld = 1'b0;
    logic [REG_W-1:0] ex_rt = '0;
    logic [REG_W-1:0] rs = '0;
    logic [REG_W-1:0] rt = '0;
    logic             urt = 1'b0;
    logic             br = 1'b0;
    logic             ma = 1'b0;
    logic             rdy = 1'b1;

    logic        pcw [N];
    logic        ifw [N];
    logic        fl  [N];
    logic        bb  [N];
    logic        fz  [N];
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    int lat  [N] = '{1, 3, 3};
    int cmax [N] = '{65535, 65535, 15};
    int m_left [N];
    int m_prd  [N];
    int m_cnt  [N];
    int bub_seen [N];
    int frz_seen [N];
    int fl_seen  [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_W(REG_W), .LOAD_LAT(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .id_ex_mem_read(ld), .id_ex_rt(ex_rt), .if_id_rs(rs),
        .if_id_rt(rt), .if_id_uses_rt(urt), .ex_branch_taken(br), .mem_access(ma),
        .dmem_ready(rdy), .pc_write(pcw[0]), .if_id_write(ifw[0]), .if_id_flush(fl[0]),
        .id_ex_bubble(bb[0]), .pipe_freeze(fz[0]), .stall_count(cnt0));

    hazard_stall_ctrl #(.REG_W(REG_W), .LOAD_LAT(3), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_ex_mem_read(ld), .id_ex_rt(ex_rt), .if_id_rs(rs),
        .if_id_rt(rt), .if_id_uses_rt(urt), .ex_branch_taken(br), .mem_access(ma),
        .dmem_ready(rdy), .pc_write(pcw[1]), .if_id_write(ifw[1]), .if_id_flush(fl[1]),
        .id_ex_bubble(bb[1]), .pipe_freeze(fz[1]), .stall_count(cnt1));

    hazard_stall_ctrl #(.REG_W(REG_W), .LOAD_LAT(3), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .id_ex_mem_read(ld), .id_ex_rt(ex_rt), .if_id_rs(rs),
        .if_id_rt(rt), .if_id_uses_rt(urt), .ex_branch_taken(br), .mem_access(ma),
        .dmem_ready(rdy), .pc_write(pcw[2]), .if_id_write(ifw[2]), .if_id_flush(fl[2]),
        .id_ex_bubble(bb[2]), .pipe_freeze(fz[2]), .stall_count(cnt2));

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned dut_cnt(input int i);
        case (i)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    function automatic bit m_hit(input int r);
        return (r != 0) && ((r == int'(rs)) || (urt && (r == int'(rt))));
    endfunction

    // Expected {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}.
    function automatic logic [4:0] model_out(input int i);
        if (!rst_n)                                   return 5'b11000;
        if (ma && !rdy)                               return 5'b00001;
        if (br)                                       return 5'b11110;
        if (ld && m_hit(int'(ex_rt)))                 return 5'b00010;
        if (m_left[i] > 0 && m_hit(m_prd[i]))         return 5'b00010;
        return 5'b11000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_left[i] = 0;
            m_prd[i]  = 0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic eval_all();
        logic [4:0] e, g;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                m_left[i] = 0;
                m_cnt[i]  = 0;
            end
            e = model_out(i);
            g = {pcw[i], ifw[i], fl[i], bb[i], fz[i]};
            check($sformatf("ctl%0d", i), int'(g), int'(e));
            check($sformatf("cnt%0d", i), dut_cnt(i), m_cnt[i]);
            bub_seen[i] += int'(bb[i]);
            frz_seen[i] += int'(fz[i]);
            fl_seen[i]  += int'(fl[i]);
            if (rst_n) begin
                if (!e[4] && m_cnt[i] < cmax[i]) m_cnt[i]++;
                if (ma && !rdy) begin
                end else if (br) begin
                    m_left[i] = 0;
                end else if (ld && m_hit(int'(ex_rt))) begin
                    m_left[i] = lat[i] - 1;
                    m_prd[i]  = int'(ex_rt);
                end else if (m_left[i] > 0 && m_hit(m_prd[i])) begin
                    m_left[i]--;
                end else begin
                    m_left[i] = 0;
                end
            end
        end
    endtask

    task automatic clr_seen();
        for (int i = 0; i < N; i++) begin
            bub_seen[i] = 0;
            frz_seen[i] = 0;
            fl_seen[i]  = 0;
        end
    endtask

    task automatic set_in(input logic l, input int e, input int s, input int t, input logic u,
                          input logic b, input logic m, input logic r);
        ld = l; ex_rt = REG_W'(e); rs = REG_W'(s); rt = REG_W'(t); urt = u;
        br = b; ma = m; rdy = r;
    endtask

    task automatic idle();
        set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic run_cycle();
        #1;
        eval_all();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset asynchronously, leaving the current inputs untouched.
    task automatic do_reset(input bit chk_mid);
        rst_n = 1'b0;
        #1;
        if (chk_mid) begin
            check("rst_mid_pcw", int'(pcw[1]), 1);
            check("rst_mid_cnt", dut_cnt(1), 0);
        end
        eval_all();
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        model_reset();
        clr_seen();
    endtask

    initial begin
        model_reset();
        clr_seen();
        #1;
        check("reset_pcw", int'(pcw[0]), 1);
        check("reset_ifw", int'(ifw[1]), 1);
        check("reset_bub", int'(bb[1]), 0);
        check("reset_cnt", dut_cnt(1), 0);
        @(negedge clk);
        do_reset(0);

        // Single-bubble load-use on $5.
        set_in(1'b1, 5, 5, 0, 1'b0, 1'b0, 1'b0, 1'b1); run_cycle();
        idle(); rs = 5; run_cycle();
        check("t1_bub", bub_seen[0], 1);
        check("t1_cnt", dut_cnt(0), 1);

        // $zero never stalls; rt matters only when read.
        do_reset(0);
        set_in(1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1); run_cycle();
        check("t2_zero", bub_seen[0], 0);
        set_in(1'b1, 5, 1, 5, 1'b1, 1'b0, 1'b0, 1'b1); run_cycle();
        check("t2_sw", bub_seen[0], 1);
        set_in(1'b1, 5, 1, 5, 1'b0, 1'b0, 1'b0, 1'b1); run_cycle();
        check("t2_addi", bub_seen[0], 1);

        // Three-cycle load latency.
        do_reset(0);
        set_in(1'b1, 7, 7, 0, 1'b0, 1'b0, 1'b0, 1'b1); run_cycle();
        for (int k = 0; k < 4; k++) begin idle(); rs = 7; run_cycle(); end
        check("t3_bub", bub_seen[1], 3);
        check("t3_cnt", dut_cnt(1), 3);

        // Memory freeze in the middle of a load-use stall.
        do_reset(0);
        set_in(1'b1, 7, 7, 0, 1'b0, 1'b0, 1'b0, 1'b1); run_cycle();
        for (int k = 0; k < 4; k++) begin idle(); rs = 7; ma = 1'b1; rdy = 1'b0; run_cycle(); end
        idle(); rs = 7; ma = 1'b1; run_cycle();
        for (int k = 0; k < 2; k++) begin idle(); rs = 7; run_cycle(); end
        check("t4_frz", frz_seen[1], 4);
        check("t4_bub", bub_seen[1], 3);
        check("t4_cnt", dut_cnt(1), 7);

        // Branch cancels a pending load wait.
        do_reset(0);
        set_in(1'b1, 7, 7, 0, 1'b0, 1'b0, 1'b0, 1'b1); run_cycle();
        idle(); rs = 7; br = 1'b1; run_cycle();
        idle(); rs = 7; run_cycle();
        check("t5_flush", fl_seen[1], 1);
        check("t5_bub", bub_seen[1], 2);
        check("t5_cnt", dut_cnt(1), 1);

        // Reset while waiting on a load, then while frozen.
        do_reset(0);
        set_in(1'b1, 7, 7, 0, 1'b0, 1'b0, 1'b0, 1'b1); run_cycle();
        idle(); rs = 7;
        do_reset(1);
        set_in(1'b1, 7, 7, 0, 1'b0, 1'b0, 1'b0, 1'b1); run_cycle();
        idle(); rs = 7; ma = 1'b1; rdy = 1'b0; run_cycle();
        do_reset(1);

        // Saturation of the narrow counter.
        for (int k = 0; k < 20; k++) begin idle(); ma = 1'b1; rdy = 1'b0; run_cycle(); end
        idle(); run_cycle();
        check("t6_sat", dut_cnt(2), 15);
        check("t6_wide", dut_cnt(0), 20);

        // Random traffic.
        do_reset(0);
        for (int k = 0; k < 1500; k++) begin
            set_in(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) == 0) do_reset(0);
            else run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
